// File: rtl/simple_spi_master_if.sv
// Host-side handshake plus SPI pin bundle for simple_spi_master.
interface simple_spi_master_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] value_mosi;
  logic [WIDTH-1:0] value_miso;
  logic             busy;
  logic             done;
  logic             pin_ncs;
  logic             pin_clk;
  logic             pin_mosi;
  logic             pin_miso;

  modport master (
    input  start, value_mosi, pin_miso,
    output value_miso, busy, done, pin_ncs, pin_clk, pin_mosi
  );

  modport slave (
    output start, value_mosi, pin_miso,
    input  value_miso, busy, done, pin_ncs, pin_clk, pin_mosi
  );
endinterface

// File: rtl/simple_spi_master.sv
// Single-word SPI master, MSB first, MOSI changes on falling SCK, MISO sampled at the fall.
// Every pin output is a flop; MISO passes through a 2-flop synchronizer.
module simple_spi_master #(
  parameter int       WIDTH    = 32,
  parameter bit       CPOL     = 1'b0,
  parameter int       CLK_DIV  = 4,
  parameter int       CS_DELAY = 4
) (
  input  logic                 system_clk,
  input  logic                 system_rst_n,
  simple_spi_master_if.master  bus
);
  localparam int MAXC = (CLK_DIV > CS_DELAY) ? CLK_DIV : CS_DELAY;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SETUP, CLK_HIGH, CLK_LOW, HOLD, GAP} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, val_q, val_d;
  logic             ncs_q, ncs_d, clk_q, clk_d, mosi_q, mosi_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [1:0]       sync_q;
  logic             miso_sync, phase_end, last_bit;

  assign miso_sync = sync_q[1];
  assign last_bit  = (bit_cnt_q == BW'(WIDTH - 1));

  always_comb begin
    phase_end = 1'b0;
    case (state_q)
      SETUP, HOLD, GAP:  phase_end = (cnt_q == CW'(CS_DELAY - 1));
      CLK_HIGH, CLK_LOW: phase_end = (cnt_q == CW'(CLK_DIV - 1));
      default:           phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || phase_end) ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE:     if (bus.start) state_d = SETUP;
      SETUP:    if (phase_end) state_d = CLK_HIGH;
      // The low phase after the last fall is absorbed into HOLD.
      CLK_HIGH: if (phase_end) state_d = last_bit ? HOLD : CLK_LOW;
      CLK_LOW:  if (phase_end) state_d = CLK_HIGH;
      HOLD:     if (phase_end) state_d = GAP;
      GAP:      if (phase_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d      = tx_q;
    rx_d      = rx_q;
    val_d     = val_q;
    bit_cnt_d = bit_cnt_q;
    ncs_d     = ncs_q;
    clk_d     = clk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        mosi_d = 1'b0;
        if (bus.start) begin
          tx_d      = bus.value_mosi;
          ncs_d     = 1'b0;
          mosi_d    = bus.value_mosi[WIDTH-1];
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      SETUP, CLK_LOW: if (phase_end) clk_d = ~CPOL;
      CLK_HIGH: if (phase_end) begin
        clk_d     = CPOL;
        rx_d      = {rx_q[WIDTH-2:0], miso_sync};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (!last_bit) begin
          tx_d   = {tx_q[WIDTH-2:0], 1'b0};
          mosi_d = tx_q[WIDTH-2];
        end
      end
      HOLD: if (phase_end) begin
        ncs_d  = 1'b1;
        mosi_d = 1'b0;
        val_d  = rx_q;
        done_d = 1'b1;
      end
      GAP: if (phase_end) busy_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      tx_q      <= '0;
      rx_q      <= '0;
      val_q     <= '0;
      bit_cnt_q <= '0;
      ncs_q     <= 1'b1;
      clk_q     <= CPOL;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sync_q    <= '0;
    end else begin
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      val_q     <= val_d;
      bit_cnt_q <= bit_cnt_d;
      ncs_q     <= ncs_d;
      clk_q     <= clk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sync_q    <= {sync_q[0], bus.pin_miso};
    end
  end

  assign bus.pin_ncs    = ncs_q;
  assign bus.pin_clk    = clk_q;
  assign bus.pin_mosi   = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.value_miso = val_q;
endmodule

// File: tb/tb_simple_spi_master.sv
// Directed bench: 8-bit mode-0 master against a behavioural slave, plus a 32-bit CPOL=1 loopback.
module tb_simple_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simple_spi_master_if #(.WIDTH(8))  ba();
  simple_spi_master_if #(.WIDTH(32)) bb();

  simple_spi_master #(.WIDTH(8), .CPOL(1'b0), .CLK_DIV(4), .CS_DELAY(4)) dut_a (
    .system_clk(clk), .system_rst_n(rst_n), .bus(ba.master));
  simple_spi_master #(.WIDTH(32), .CPOL(1'b1), .CLK_DIV(4), .CS_DELAY(4)) dut_b (
    .system_clk(clk), .system_rst_n(rst_n), .bus(bb.master));

  assign bb.pin_miso = bb.pin_mosi;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Mode-0 slave sampled on system_clk: edges are seen one cycle late, well inside each phase.
  logic [7:0] s_tx, s_sh, s_rx;
  logic       s_pclk, s_pncs;
  always @(posedge clk) begin
    if (!rst_n) begin
      ba.pin_miso <= 1'b0;
      s_pclk <= 1'b0;
      s_pncs <= 1'b1;
      s_sh   <= '0;
      s_rx   <= '0;
    end else begin
      s_pclk <= ba.pin_clk;
      s_pncs <= ba.pin_ncs;
      if (s_pncs && !ba.pin_ncs) begin
        s_sh        <= s_tx;
        s_rx        <= '0;
        ba.pin_miso <= s_tx[7];
      end else if (!ba.pin_ncs) begin
        if (!s_pclk && ba.pin_clk) s_rx <= {s_rx[6:0], ba.pin_mosi};
        if (s_pclk && !ba.pin_clk) begin
          s_sh        <= {s_sh[6:0], 1'b0};
          ba.pin_miso <= s_sh[6];
        end
      end
    end
  end

  int         ncs_fall_q[$], ncs_rise_q[$], done_q[$];
  int         first_rise, last_fall, rises, falls, mosi_bad, idle_bad, busy_fall, busy_gap;
  logic [7:0] miso_at_done;

  // Cycle c = state after the c-th rising edge following the cycle start is first high.
  task automatic run(input logic [7:0] mo, input bit hold, input int p1, input int p2,
                     input int rst_at, input int ncyc);
    logic pn, pc, pm, pb;
    ncs_fall_q.delete(); ncs_rise_q.delete(); done_q.delete();
    first_rise = -1; last_fall = -1; rises = 0; falls = 0; mosi_bad = 0;
    idle_bad = 0; busy_fall = -1; busy_gap = 0; miso_at_done = '0;
    @(negedge clk);
    ba.value_mosi = mo;
    ba.start = 1'b1;
    pn = ba.pin_ncs; pc = ba.pin_clk; pm = ba.pin_mosi; pb = ba.busy;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ncs", ba.pin_ncs, 1'b1);
        chk("rst_clk", ba.pin_clk, 1'b0);
        chk("rst_mosi", ba.pin_mosi, 1'b0);
        chk("rst_busy", ba.busy, 1'b0);
        chk("rst_val", ba.value_miso, 8'h00);
      end
      if (rst_at > 0 && c == rst_at + 3) rst_n = 1'b1;
      ba.start = hold || c == p1 || c == p2;
      if (!hold) ba.value_mosi = ~mo;
      if (pn && !ba.pin_ncs) ncs_fall_q.push_back(c);
      if (!pn && ba.pin_ncs) ncs_rise_q.push_back(c);
      if (!ba.pin_ncs && !pc && ba.pin_clk) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        if (ba.pin_mosi !== pm) mosi_bad++;
      end
      if (!ba.pin_ncs && pc && !ba.pin_clk) begin
        falls++;
        last_fall = c;
      end
      if (ba.pin_ncs && ba.pin_clk !== 1'b0) idle_bad++;
      if (ba.done) begin
        done_q.push_back(c);
        miso_at_done = ba.value_miso;
      end
      if (pb && !ba.busy && busy_fall < 0) busy_fall = c;
      if (!ba.busy && busy_fall < 0 && rst_at < 0) busy_gap++;
      pn = ba.pin_ncs; pc = ba.pin_clk; pm = ba.pin_mosi; pb = ba.busy;
    end
    ba.start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] mo;
    logic [7:0] so;
    logic [7:0] exp_miso;
    int         exp_rise;
    int         exp_lfall;
    int         exp_done;
    int         exp_bfall;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int done_b, rises_b, idle_bad_b;
    logic [31:0] val_b;
    logic pcb;
    vecs[0] = '{8'hA5, 8'h3C, 8'h3C, 5, 65, 69, 73};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 5, 65, 69, 73};
    vecs[2] = '{8'h00, 8'hFF, 8'hFF, 5, 65, 69, 73};
    vecs[3] = '{8'h81, 8'h7E, 8'h7E, 5, 65, 69, 73};

    ba.start = 1'b0; ba.value_mosi = '0; bb.start = 1'b0; bb.value_mosi = '0;
    s_tx = '0;
    idle(3);
    chk("reset_ncs", ba.pin_ncs, 1'b1);
    chk("reset_clk_a", ba.pin_clk, 1'b0);
    chk("reset_clk_b", bb.pin_clk, 1'b1);
    chk("reset_mosi", ba.pin_mosi, 1'b0);
    chk("reset_busy", ba.busy, 1'b0);
    chk("reset_done", ba.done, 1'b0);
    chk("reset_val", ba.value_miso, 8'h00);
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 4; i++) begin
      s_tx = vecs[i].so;
      run(vecs[i].mo, 1'b0, -1, -1, -1, 80);
      chk($sformatf("v%0d_ncs_windows", i), ncs_fall_q.size(), 1);
      chk($sformatf("v%0d_ncs_fall", i), ncs_fall_q[0], 1);
      chk($sformatf("v%0d_first_rise", i), first_rise, vecs[i].exp_rise);
      chk($sformatf("v%0d_last_fall", i), last_fall, vecs[i].exp_lfall);
      chk($sformatf("v%0d_ncs_rise", i), ncs_rise_q[0], vecs[i].exp_done);
      chk($sformatf("v%0d_done_count", i), done_q.size(), 1);
      chk($sformatf("v%0d_done_cycle", i), done_q[0], vecs[i].exp_done);
      chk($sformatf("v%0d_miso_at_done", i), miso_at_done, vecs[i].exp_miso);
      chk($sformatf("v%0d_busy_fall", i), busy_fall, vecs[i].exp_bfall);
      chk($sformatf("v%0d_busy_gap", i), busy_gap, 0);
      chk($sformatf("v%0d_rises", i), rises, 8);
      chk($sformatf("v%0d_falls", i), falls, 8);
      chk($sformatf("v%0d_mosi_stable", i), mosi_bad, 0);
      chk($sformatf("v%0d_clk_idle", i), idle_bad, 0);
      chk($sformatf("v%0d_slave_rx", i), s_rx, vecs[i].mo);
      chk($sformatf("v%0d_val_held", i), ba.value_miso, vecs[i].exp_miso);
      idle(4);
    end

    // start pulses while busy are dropped, not queued
    s_tx = 8'h96;
    run(8'hA5, 1'b0, 10, 70, -1, 90);
    chk("ign_ncs_windows", ncs_fall_q.size(), 1);
    chk("ign_done_count", done_q.size(), 1);
    chk("ign_busy_gap", busy_gap, 0);
    chk("ign_busy_fall", busy_fall, 73);
    chk("ign_miso", miso_at_done, 8'h96);
    idle(4);

    // start held high: back-to-back transfers
    s_tx = 8'hC3;
    run(8'h5A, 1'b1, -1, -1, -1, 145);
    chk("b2b_fall0", ncs_fall_q[0], 1);
    chk("b2b_rise0", ncs_rise_q[0], 69);
    chk("b2b_fall1", ncs_fall_q[1], 74);
    chk("b2b_gap", ncs_fall_q[1] - ncs_rise_q[0], 5);
    chk("b2b_done_count", done_q.size(), 2);
    chk("b2b_done1", done_q[1], 142);
    chk("b2b_miso", miso_at_done, 8'hC3);
    idle(10);

    // reset mid-transfer aborts without a done
    s_tx = 8'h3C;
    run(8'hA5, 1'b0, -1, -1, 30, 70);
    chk("abort_done_count", done_q.size(), 0);
    chk("abort_val", ba.value_miso, 8'h00);
    chk("abort_ncs", ba.pin_ncs, 1'b1);
    chk("abort_busy", ba.busy, 1'b0);
    chk("abort_clk_idle", idle_bad, 0);
    idle(3);
    run(8'hA5, 1'b0, -1, -1, -1, 80);
    chk("after_done_cycle", done_q[0], 69);
    chk("after_miso", miso_at_done, 8'h3C);
    chk("after_slave_rx", s_rx, 8'hA5);

    // CPOL=1, 32-bit loopback
    done_b = -1; rises_b = 0; idle_bad_b = 0; val_b = '0;
    @(negedge clk);
    chk("b_idle_clk", bb.pin_clk, 1'b1);
    bb.value_mosi = 32'hDEADBEEF;
    bb.start = 1'b1;
    pcb = bb.pin_clk;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      bb.start = 1'b0;
      bb.value_mosi = 32'h0;
      if (!bb.pin_ncs && pcb && !bb.pin_clk) rises_b++;
      if (bb.pin_ncs && bb.pin_clk !== 1'b1) idle_bad_b++;
      if (bb.done && done_b < 0) begin
        done_b = c;
        val_b  = bb.value_miso;
      end
      pcb = bb.pin_clk;
    end
    chk("b_done_cycle", done_b, 261);
    chk("b_value", val_b, 32'hDEADBEEF);
    chk("b_rises", rises_b, 32);
    chk("b_clk_idle", idle_bad_b, 0);
    chk("b_busy_end", bb.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simple_spi_master.md
Name: simple_spi_master

Overview:
SPI master that exchanges one fixed-WIDTH word per transfer with an external SPI slave, including slaves built from our own SPI slave block. A `start` pulse loads the outgoing word, asserts chip select, generates WIDTH clock pulses and shifts data MSB first. At the end it presents the received word with a one-cycle `done` strobe. The block sits between system logic and the SPI pins and runs entirely on `system_clk`.

Parameters:
WIDTH, 32, bits per transfer (>=2)
CPOL, 1'b0, idle clock level; 0 = SPI mode 0, 1 = inverted clock with the same sampling relation
CLK_DIV, 4, system_clk cycles per SCK half-period (>=2; >=4 required when driving our slave)
CS_DELAY, 4, system_clk cycles for each of: ncs-low to first SCK edge, last SCK edge to ncs-high, and minimum ncs-high gap (>=1)

Ports:
system_clk  input  1  single clock; all logic on rising edge
system_rst_n  input  1  asynchronous active-low reset
start  input  1  request a transfer; accepted only when busy=0
value_mosi  input  WIDTH  word to transmit; captured on the accepted start
value_miso  output  WIDTH  last received word; updated only with done
busy  output  1  high from the cycle after an accepted start until the gap ends
done  output  1  one-cycle strobe; value_miso valid from this cycle on
pin_ncs  output  1  chip select, active low
pin_clk  output  1  SCK; idles at CPOL
pin_mosi  output  1  MOSI; shift register MSB
pin_miso  input  1  MISO; asynchronous, passes through a 2-flop synchronizer

Behaviour:
- Reset (async assert, sync release): pin_ncs=1, pin_clk=CPOL, pin_mosi=0, busy=0, done=0, value_miso=0, all counters 0, state IDLE, synchronizer 0.
- Reset asserted mid-transfer aborts immediately. Pins go to their idle values asynchronously, done is not pulsed, and value_miso keeps its reset value of 0.
- All pin outputs come directly from registers.
- States: IDLE -> SETUP -> CLK_HIGH <-> CLK_LOW -> HOLD -> GAP -> IDLE.
- IDLE: pin_mosi=0. When start=1 at cycle 0:
  - at cycle 1: tx_shift<=value_mosi, pin_ncs<=0, pin_mosi<=value_mosi[WIDTH-1], busy<=1, bit_counter<=0, enter SETUP.
- SETUP: hold for CS_DELAY cycles. The first SCK rise is at cycle 1+CS_DELAY.
- Logical SCK high (pin_clk = ~CPOL) lasts CLK_DIV cycles, then logical low lasts CLK_DIV cycles. Rise k (k=0..WIDTH-1) occurs at cycle 1+CS_DELAY+2k*CLK_DIV.
- At each falling edge, in the same cycle:
  - rx_shift <= {rx_shift[WIDTH-2:0], miso_sync}, where miso_sync is the synchronizer output sampled at the edge cycle. This captures MISO as it was during the high phase.
  - bit_counter increments.
  - If bit_counter < WIDTH after increment, shift tx_shift left and update pin_mosi, so MOSI changes only on falling edges. Otherwise go to HOLD with pin_clk at CPOL and pin_mosi unchanged.
- Last fall is at cycle 1+CS_DELAY+(2*WIDTH-1)*CLK_DIV.
- HOLD: CS_DELAY cycles, then:
  - pin_ncs<=1, pin_mosi<=0, value_miso<=rx_shift, done<=1 for one cycle;
  - enter GAP.
- GAP: CS_DELAY cycles with busy=1, then busy<=0 and enter IDLE.
- ncs-high cycle T_done = 1+2*CS_DELAY+(2*WIDTH-1)*CLK_DIV. busy falls at T_done+CS_DELAY.
- start while busy=1 is ignored and not queued. If start is held high, the next transfer is accepted in the first cycle busy=0, and ncs falls the cycle after.
- value_mosi changes after acceptance have no effect.
- pin_clk never toggles while pin_ncs=1. Exactly WIDTH rising and WIDTH falling SCK edges occur per transfer.
- Counter widths: bit_counter $clog2(WIDTH+1); divider counter $clog2(max(CLK_DIV,CS_DELAY)+1).

Test Plan:
1. WIDTH=8, CLK_DIV=4, CS_DELAY=4, start at cycle 0 with value_mosi=8'hA5, bench slave returns 8'h3C -> pin_ncs falls at cycle 1; first rise at 5; last fall at 65; ncs rises and done=1 at 69 with value_miso=8'h3C; busy falls at 73; slave captured 8'hA5.
2. Same transfer, count edges and check MOSI stability -> exactly 8 rises and 8 falls while ncs=0; pin_mosi stable across every rise; pin_clk=0 whenever ncs=1.
3. start pulsed at cycles 10 and 70 during transfer 1 -> both ignored: one ncs-low window only, a single done pulse, busy continuous.
4. start held high constantly -> back-to-back transfers; ncs high for CS_DELAY+1=5 cycles between them; one done per transfer.
5. system_rst_n asserted at cycle 30 mid-transfer -> pin_ncs=1 and pin_clk=CPOL immediately; busy=0, done never pulses, value_miso=0; a start after release completes normally.
6. CPOL=1, WIDTH=32 loopback (pin_mosi tied to pin_miso), value_mosi=32'hDEADBEEF -> pin_clk idles at 1; value_miso=32'hDEADBEEF at done.
